i2c_slave_rx: RTL and testbench

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_slave_rx.sv | 246 ++++++++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave receiver.
// Synchronizes SCL/SDA, detects START/STOP, matches a 7-bit write address,
// ACKs up to MAX_BY data bytes and presents each byte as a one-cycle pulse.
module i2c_slave_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BY      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [6:0] i_own_add,
  input  logic       scl_i2c,
  inout  wire        sda_i2c,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_first,
  output logic       o_detect,
  output logic       o_busy,
  output logic       o_stop,
  output logic [3:0] o_cnt_by,
  output logic       o_ovf,
  output logic       o_err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  // Reset name is historical: the level is active-high.
  logic clear;
  assign clear = i_rst_n || !i_en;

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_dly_reg;
  logic                   sda_dly_reg;
  logic [2:0]             guard_reg;

  logic scl_s, sda_s, armed;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic       mid_reg, mid_next;
  logic       sda_oe_reg, sda_oe_next;
  logic [7:0] data_reg, data_next;
  logic       valid_reg, valid_next;
  logic       first_reg, first_next;
  logic       first_pend_reg, first_pend_next;
  logic       detect_reg, detect_next;
  logic       busy_reg, busy_next;
  logic       stop_reg, stop_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       ovf_reg, ovf_next;
  logic       err_reg, err_next;

  logic [7:0] byte_in;
  logic [3:0] cnt_inc;
  logic       in_byte;

  // Input synchronizers plus a short guard window so the refill after reset
  // can never be mistaken for a bus condition.
  always_ff @(posedge i_clk) begin
    if (clear) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_dly_reg  <= 1'b1;
      sda_dly_reg  <= 1'b1;
      guard_reg    <= 3'(SYNC_STAGES + 1);
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i2c};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i2c};
      scl_dly_reg  <= scl_sync_reg[SYNC_STAGES-1];
      sda_dly_reg  <= sda_sync_reg[SYNC_STAGES-1];
      if (guard_reg != 3'd0) guard_reg <= guard_reg - 3'd1;
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign armed     = (guard_reg == 3'd0);
  assign scl_rise  = armed &&  scl_s && !scl_dly_reg;
  assign scl_fall  = armed && !scl_s &&  scl_dly_reg;
  assign start_det = armed && scl_s &&  sda_dly_reg && !sda_s;
  assign stop_det  = armed && scl_s && !sda_dly_reg &&  sda_s;

  // Next-state and datapath decisions for the receive FSM.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    mid_next        = mid_reg;
    sda_oe_next     = sda_oe_reg;
    data_next       = data_reg;
    valid_next      = 1'b0;
    first_next      = first_reg;
    first_pend_next = first_pend_reg;
    detect_next     = detect_reg;
    busy_next       = busy_reg;
    stop_next       = 1'b0;
    cnt_next        = cnt_reg;
    ovf_next        = ovf_reg;
    err_next        = err_reg;
    byte_in         = {shift_reg, sda_s};
    cnt_inc         = (cnt_reg == 4'hF) ? 4'hF : cnt_reg + 4'd1;
    // The SCL high phase that precedes a START/STOP also raises the bit
    // counter; a byte only counts as "in progress" once that first bit's
    // SCL has fallen, so mid_reg marks a completed bit inside the byte.
    in_byte         = ((state_reg == ADDR) || (state_reg == DATA)) && mid_reg;

    if (stop_det) begin
      state_next   = IDLE;
      stop_next    = 1'b1;
      busy_next    = 1'b0;
      detect_next  = 1'b0;
      sda_oe_next  = 1'b0;
      bit_cnt_next = 3'd0;
      mid_next     = 1'b0;
      if (in_byte) err_next = 1'b1;
    end else if (start_det) begin
      state_next      = ADDR;
      busy_next       = 1'b1;
      detect_next     = 1'b0;
      sda_oe_next     = 1'b0;
      bit_cnt_next    = 3'd0;
      mid_next        = 1'b0;
      cnt_next        = 4'd0;
      ovf_next        = 1'b0;
      first_pend_next = 1'b1;
      err_next        = in_byte;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shift_next = byte_in[6:0];
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_next = 3'd0;
              mid_next     = 1'b0;
              if ((byte_in[7:1] == i_own_add) && !byte_in[0]) begin
                state_next  = ADDR_ACK;
                detect_next = 1'b1;
              end else begin
                state_next = IGNORE;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end else if (scl_fall && (bit_cnt_reg != 3'd0)) begin
            mid_next = 1'b1;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // First falling edge starts the ACK, the next one ends it.
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next = 1'b0;
              state_next  = DATA;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_next = byte_in[6:0];
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_next    = 3'd0;
              mid_next        = 1'b0;
              data_next       = byte_in;
              valid_next      = 1'b1;
              first_next      = first_pend_reg;
              first_pend_next = 1'b0;
              cnt_next        = cnt_inc;
              if (int'(cnt_inc) <= MAX_BY) begin
                state_next = DATA_ACK;
              end else begin
                ovf_next   = 1'b1;
                state_next = IGNORE;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end else if (scl_fall && (bit_cnt_reg != 3'd0)) begin
            mid_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; disable clears all but the error flag.
  always_ff @(posedge i_clk) begin
    if (clear) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 7'd0;
      mid_reg        <= 1'b0;
      sda_oe_reg     <= 1'b0;
      data_reg       <= 8'd0;
      valid_reg      <= 1'b0;
      first_reg      <= 1'b0;
      first_pend_reg <= 1'b0;
      detect_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      stop_reg       <= 1'b0;
      cnt_reg        <= 4'd0;
      ovf_reg        <= 1'b0;
      err_reg        <= i_rst_n ? 1'b0 : err_reg;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      mid_reg        <= mid_next;
      sda_oe_reg     <= sda_oe_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      first_reg      <= first_next;
      first_pend_reg <= first_pend_next;
      detect_reg     <= detect_next;
      busy_reg       <= busy_next;
      stop_reg       <= stop_next;
      cnt_reg        <= cnt_next;
      ovf_reg        <= ovf_next;
      err_reg        <= err_next;
    end
  end

  assign sda_i2c  = sda_oe_reg ? 1'b0 : 1'bz;
  assign o_data   = data_reg;
  assign o_valid  = valid_reg;
  assign o_first  = first_reg;
  assign o_detect = detect_reg;
  assign o_busy   = busy_reg;
  assign o_stop   = stop_reg;
  assign o_cnt_by = cnt_reg;
  assign o_ovf    = ovf_reg;
  assign o_err    = err_reg;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: bit-banged I2C master, transfer-level reference model
// and a scoreboard monitor for the received-byte stream.
module tb_i2c_slave_rx;

  localparam int MAX_BY = 2;
  localparam int Q      = 8;   // system clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [6:0] own_add = 7'h2A;
  logic       scl = 1'b1;
  logic       sda_rel = 1'b1;  // 1 = master releases SDA
  wire        sda_bus;

  assign sda_bus = sda_rel ? 1'bz : 1'b0;
  pullup (sda_bus);

  logic [7:0] o_data;
  logic       o_valid, o_first, o_detect, o_busy, o_stop, o_ovf, o_err;
  logic [3:0] o_cnt_by;

  i2c_slave_rx #(.SYNC_STAGES(2), .MAX_BY(MAX_BY)) dut (
    .i_clk(clk), .i_rst_n(rst), .i_en(en), .i_own_add(own_add),
    .scl_i2c(scl), .sda_i2c(sda_bus),
    .o_data(o_data), .o_valid(o_valid), .o_first(o_first),
    .o_detect(o_detect), .o_busy(o_busy), .o_stop(o_stop),
    .o_cnt_by(o_cnt_by), .o_ovf(o_ovf), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int stop_seen = 0;
  int stop_exp  = 0;
  int slave_low = 0;  // cycles the slave pulled SDA low

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } vexp_t;

  vexp_t      exp_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every o_valid pulse must match the next expected byte.
  always @(negedge clk) begin : monitor
    vexp_t e;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got o_data %02h, required no o_valid", o_data);
      end else begin
        e = exp_q.pop_front();
        check("valid_data", {24'd0, o_data}, {24'd0, e.data});
        check("valid_first", {31'd0, o_first}, {31'd0, e.first});
      end
    end
    if (o_stop) stop_seen++;
    if (sda_rel && (sda_bus === 1'b0)) slave_low++;
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_rel = 1'b1; wait_q();
    scl = 1'b1;     wait_q();
    sda_rel = 1'b0; wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic bus_stop();
    sda_rel = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    sda_rel = 1'b1; wait_q();
    stop_exp++;
  endtask

  task automatic send_bit(input logic b);
    sda_rel = b; wait_q();
    scl = 1'b1;  wait_q(); wait_q();
    scl = 1'b0;  wait_q();
  endtask

  task automatic get_ack(output logic ack);
    sda_rel = 1'b1; wait_q();
    scl = 1'b1;     wait_q();
    ack = (sda_bus === 1'b0);
    wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(ack);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"},   {24'd0, o_data}, 32'd0);
    check({tag, "_valid"},  {31'd0, o_valid}, 32'd0);
    check({tag, "_first"},  {31'd0, o_first}, 32'd0);
    check({tag, "_detect"}, {31'd0, o_detect}, 32'd0);
    check({tag, "_busy"},   {31'd0, o_busy}, 32'd0);
    check({tag, "_stop"},   {31'd0, o_stop}, 32'd0);
    check({tag, "_cnt"},    {28'd0, o_cnt_by}, 32'd0);
    check({tag, "_ovf"},    {31'd0, o_ovf}, 32'd0);
    check({tag, "_err"},    {31'd0, o_err}, 32'd0);
    check({tag, "_sda"},    {31'd0, sda_bus}, 32'd1);
  endtask

  // Full transfer: START, address, every byte in tx_q, STOP. Expectations
  // come from the protocol rules: a write to own address is ACKed, data
  // bytes are ACKed while their running count stays within MAX_BY, the
  // first overflowing byte is still reported but NACKed, later ones ignored.
  task automatic transfer(input logic [7:0] addr);
    logic match, ack, exp_ack, listening;
    int   cnt;
    match     = (addr[7:1] == own_add) && !addr[0];
    listening = match;
    cnt       = 0;
    slave_low = 0;
    bus_start();
    send_byte(addr, ack);
    check("addr_ack", {31'd0, ack}, {31'd0, match});
    for (int i = 0; i < tx_q.size(); i++) begin
      if (listening) begin
        cnt++;
        exp_q.push_back({(cnt == 1), tx_q[i]});
        exp_ack = (cnt <= MAX_BY);
        if (!exp_ack) listening = 1'b0;
      end else begin
        exp_ack = 1'b0;
      end
      send_byte(tx_q[i], ack);
      check("data_ack", {31'd0, ack}, {31'd0, exp_ack});
    end
    check("busy_in_xfer",   {31'd0, o_busy}, 32'd1);
    check("detect_in_xfer", {31'd0, o_detect}, {31'd0, match});
    check("ovf_in_xfer",    {31'd0, o_ovf}, {31'd0, (cnt > MAX_BY)});
    check("err_in_xfer",    {31'd0, o_err}, 32'd0);
    bus_stop();
    wait_q();
    check("busy_after_stop",   {31'd0, o_busy}, 32'd0);
    check("detect_after_stop", {31'd0, o_detect}, 32'd0);
    check("cnt_after_stop",    {28'd0, o_cnt_by}, (cnt > 15) ? 32'd15 : cnt);
    check("stop_pulses",       stop_seen, stop_exp);
    check("missing_valid",     exp_q.size(), 32'd0);
    if (!match) check("sda_never_driven", slave_low, 32'd0);
    $display("[TB] xfer addr=%02h bytes=%0d match=%0d cnt=%0d ovf=%0d",
             addr, tx_q.size(), match, o_cnt_by, o_ovf);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation still running, required to finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic ack;
    logic [7:0] a;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");
    wait_q();

    // Matching write with register byte then data byte.
    tx_q = '{8'h10, 8'hA5};
    transfer(8'h54);

    // Address mismatch and read-direction address.
    tx_q = '{8'h11};
    transfer(8'h56);
    tx_q = '{8'h77};
    transfer(8'h55);

    // Overflow: one byte more than MAX_BY, plus one ignored afterwards.
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    transfer(8'h54);

    // Repeated START in the middle of a data byte sets the error flag.
    bus_start();
    send_byte(8'h54, ack);
    check("rs_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_start();
    check("rs_err_set", {31'd0, o_err}, 32'd1);
    check("rs_detect_clr", {31'd0, o_detect}, 32'd0);
    send_byte(8'h54, ack);
    check("rs_readdr_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'h3C, ack);
    check("rs_data_ack", {31'd0, ack}, 32'd1);
    check("rs_err_held", {31'd0, o_err}, 32'd1);
    bus_start();
    check("rs_err_cleared", {31'd0, o_err}, 32'd0);
    bus_stop();
    wait_q();
    check("rs_err_after_stop", {31'd0, o_err}, 32'd0);
    $display("[TB] xfer repeated-start mid byte, err=%0d", o_err);

    // STOP inside a byte, then disable: error flag survives, rest clears.
    bus_start();
    send_byte(8'h54, ack);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    bus_stop();
    wait_q();
    check("stop_err_set", {31'd0, o_err}, 32'd1);
    en = 1'b0;
    wait_q();
    check("en_err_held", {31'd0, o_err}, 32'd1);
    check("en_busy_clr", {31'd0, o_busy}, 32'd0);
    check("en_cnt_clr", {28'd0, o_cnt_by}, 32'd0);
    en = 1'b1;
    wait_q();
    $display("[TB] xfer stop mid byte + disable, err=%0d", o_err);

    // Reset while the slave is driving the data ACK.
    bus_start();
    send_byte(8'h54, ack);
    exp_q.push_back({1'b1, 8'hA5});
    for (int i = 7; i >= 0; i--) send_bit(a_const(i));
    sda_rel = 1'b1;
    wait_q();
    check("ack_driven_before_rst", {31'd0, sda_bus}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("midrst");
    wait_q();
    bus_stop();
    wait_q();
    check("midrst_stop_pulses", stop_seen, stop_exp);
    $display("[TB] xfer reset during data ack");

    // Randomized transfers against the transfer-level model.
    for (int t = 0; t < 14; t++) begin
      a = ($urandom_range(0, 99) < 65) ? 8'h54 : 8'($urandom_range(0, 255));
      tx_q.delete();
      for (int i = 0; i < $urandom_range(0, MAX_BY + 2); i++)
        tx_q.push_back(8'($urandom_range(0, 255)));
      transfer(a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic a_const(input int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction

endmodule
